// File: rtl/pe_noc_interface.sv
// PE-side network interface: TX flit builder/FIFO toward the switch, RX payload FIFO from the switch.
// Optional macro NI_RX_DEST_CHECK_EN discards RX arrivals not addressed to this node.

module ni_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [width-1:0]   wr_data,
  input  logic               pop,
  output logic [width-1:0]   head,
  output logic [$clog2(depth):0] count
);

  localparam int aw = $clog2(depth);

  logic [width-1:0] mem_reg [depth];
  logic [aw-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [aw-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [aw:0]      count_reg, count_next;

  // Callers qualify push/pop, so no full/empty guarding is repeated here.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= wr_data;
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

module pe_noc_interface #(
  parameter int x_coord     = 0,
  parameter int y_coord     = 0,
  parameter int data_width  = 32,
  parameter int x_size      = 1,
  parameter int y_size      = 1,
  parameter int total_width = x_size + y_size + data_width,
  parameter int tx_depth    = 4,
  parameter int rx_depth    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_pe_valid,
  output logic                       o_pe_ready,
  input  logic [data_width-1:0]      i_pe_data,
  input  logic [x_size-1:0]          i_pe_dest_x,
  input  logic [y_size-1:0]          i_pe_dest_y,
  output logic                       o_noc_valid,
  input  logic                       i_noc_ready,
  output logic [total_width-1:0]     o_noc_data,
  input  logic                       i_noc_valid,
  input  logic [total_width-1:0]     i_noc_data,
  output logic                       o_pe_valid,
  input  logic                       i_pe_ready,
  output logic [data_width-1:0]      o_pe_data,
  output logic [$clog2(tx_depth):0]  o_tx_count,
  output logic [$clog2(rx_depth):0]  o_rx_count,
  output logic [15:0]                o_drop_count,
  output logic                       o_overflow
);

  localparam int tx_cw = $clog2(tx_depth) + 1;
  localparam int rx_cw = $clog2(rx_depth) + 1;
  localparam int coord_w = x_size + y_size;
  localparam logic [coord_w-1:0] local_coord = {y_size'(y_coord), x_size'(x_coord)};

  logic                   tx_push, tx_pop;
  logic [total_width-1:0] tx_flit, tx_head;
  logic [tx_cw-1:0]       tx_count;

  logic                   rx_local, rx_accept, rx_pop, rx_drop;
  logic [data_width-1:0]  rx_head;
  logic [rx_cw-1:0]       rx_count;

  logic [15:0]            drop_count_reg, drop_count_next;
  logic                   overflow_reg, overflow_next;

  // TX: build {data, dest_y, dest_x} and drain under valid/ready.
  assign tx_flit     = {i_pe_data, i_pe_dest_y, i_pe_dest_x};
  assign o_pe_ready  = (tx_count != tx_cw'(tx_depth));
  assign tx_push     = i_pe_valid & o_pe_ready;
  assign o_noc_valid = (tx_count != '0);
  assign tx_pop      = o_noc_valid & i_noc_ready;
  assign o_noc_data  = o_noc_valid ? tx_head : '0;

  ni_fifo #(
    .width (total_width),
    .depth (tx_depth)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tx_push),
    .wr_data (tx_flit),
    .pop     (tx_pop),
    .head    (tx_head),
    .count   (tx_count)
  );

`ifdef NI_RX_DEST_CHECK_EN
  assign rx_local = (i_noc_data[coord_w-1:0] == local_coord);
`else
  logic unused_rx_coord;
  assign unused_rx_coord = ^{i_noc_data[coord_w-1:0], local_coord};
  assign rx_local = 1'b1;
`endif

  // RX has no backpressure: a full FIFO still accepts if the PE frees a slot this cycle.
  assign o_pe_valid = (rx_count != '0);
  assign rx_pop     = o_pe_valid & i_pe_ready;
  assign rx_accept  = i_noc_valid & rx_local & ((rx_count != rx_cw'(rx_depth)) | rx_pop);
  assign rx_drop    = i_noc_valid & ~rx_accept;
  assign o_pe_data  = o_pe_valid ? rx_head : '0;

  ni_fifo #(
    .width (data_width),
    .depth (rx_depth)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (rx_accept),
    .wr_data (i_noc_data[total_width-1:coord_w]),
    .pop     (rx_pop),
    .head    (rx_head),
    .count   (rx_count)
  );

  always_comb begin
    drop_count_next = drop_count_reg;
    overflow_next   = overflow_reg;
    if (rx_drop) begin
      overflow_next = 1'b1;
      if (drop_count_reg != 16'hFFFF) drop_count_next = drop_count_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count_reg <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      drop_count_reg <= drop_count_next;
      overflow_reg   <= overflow_next;
    end
  end

  assign o_tx_count   = tx_count;
  assign o_rx_count   = rx_count;
  assign o_drop_count = drop_count_reg;
  assign o_overflow   = overflow_reg;

endmodule
